// File: rtl/xnor_conv_sequencer.sv
// Control sequencer for a KxK XNOR-popcount systolic array: weight load, feature-map streaming, pipeline drain.
// Optional XNOR_SEQ_WEIGHT_REUSE_EN adds cfg_reuse_w so a layer can skip weight loading.
module xnor_conv_sequencer #(
   parameter int K     = 3,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int CNT_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_start,
   input  logic       cfg_abort,
`ifdef XNOR_SEQ_WEIGHT_REUSE_EN
   input  logic       cfg_reuse_w,
`endif
   input  logic       w_valid,
   output logic       w_ready,
   input  logic       px_valid,
   output logic       px_ready,
   output logic       pe_weight_control,
   output logic       pe_start,
   output logic       pe_top_start,
   output logic       pe_side_control,
   output logic       pe_top_control,
   output logic       out_valid,
   output logic       busy,
   output logic       done,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD_W  = 3'd1,
      S_COMPUTE = 3'd2,
      S_DRAIN   = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] K_C   = CNT_W'(K);
   localparam logic [CNT_W-1:0] K_M1  = CNT_W'(K - 1);
   localparam logic [CNT_W-1:0] KK_M1 = CNT_W'(K * K - 1);
   localparam logic [CNT_W-1:0] W_M1  = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] H_M1  = CNT_W'(IMG_H - 1);

   state_t           state;
   logic [CNT_W-1:0] w_cnt;
   logic [CNT_W-1:0] col;
   logic [CNT_W-1:0] row;
   logic [CNT_W-1:0] drain_cnt;
   logic [K-1:0]     vpipe;
   logic             in_array;
   logic             win_tag;
   logic             reuse_w;

`ifdef XNOR_SEQ_WEIGHT_REUSE_EN
   assign reuse_w = cfg_reuse_w;
`else
   assign reuse_w = 1'b0;
`endif

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // ready is a decode of the state register and never looks at valid.
   assign w_ready  = (state == S_LOAD_W);
   assign px_ready = (state == S_COMPUTE);

   assign in_array          = (state == S_COMPUTE) || (state == S_DRAIN);
   assign pe_weight_control = w_ready && w_valid;
   assign pe_top_start      = px_ready && px_valid;
   assign pe_start          = pe_top_start || (state == S_DRAIN);
   assign pe_side_control   = in_array && (col < K_C);
   assign pe_top_control    = in_array && (col >= K_C) && (row != '0);
   assign out_valid         = vpipe[K-1] && pe_start;
   assign busy              = (state != S_IDLE);
   assign done              = (state == S_DONE);
   assign state_dbg         = state;

   // A beat closes a full KxK window once it is at least K-1 pixels into both axes.
   assign win_tag = (col >= K_M1) && (row >= K_M1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         w_cnt     <= '0;
         col       <= '0;
         row       <= '0;
         drain_cnt <= '0;
         vpipe     <= '0;
      end else if (cfg_abort) begin
         state     <= S_IDLE;
         w_cnt     <= '0;
         col       <= '0;
         row       <= '0;
         drain_cnt <= '0;
         vpipe     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  state     <= reuse_w ? S_COMPUTE : S_LOAD_W;
                  w_cnt     <= '0;
                  col       <= '0;
                  row       <= '0;
                  drain_cnt <= '0;
                  vpipe     <= '0;
               end
            end
            S_LOAD_W: begin
               if (w_valid) begin
                  w_cnt <= w_cnt + 1'b1;
                  if (w_cnt == KK_M1) state <= S_COMPUTE;
               end
            end
            S_COMPUTE: begin
               if (px_valid) begin
                  vpipe <= {vpipe[K-2:0], win_tag};
                  // Counters park at the last pixel so DRAIN sees (IMG_W-1, IMG_H-1).
                  if (col == W_M1) begin
                     if (row == H_M1) begin
                        state <= S_DRAIN;
                     end else begin
                        col <= '0;
                        row <= row + 1'b1;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_DRAIN: begin
               vpipe     <= {vpipe[K-2:0], 1'b0};
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_cnt == K_M1) state <= S_DONE;
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xnor_conv_sequencer.sv
// Self-checking bench for xnor_conv_sequencer: directed layer runs with randomized valid gaps,
// checked against a window/latency model derived from beat indices and pe_start ordinals.
module tb_xnor_conv_sequencer;

   localparam int K     = 3;
   localparam int IMG_W = 8;
   localparam int IMG_H = 8;
   localparam int CNT_W = 8;
   localparam int N_WIN = (IMG_W - K + 1) * (IMG_H - K + 1);
   localparam int LAT   = 1 + K * K + IMG_W * IMG_H + K + 1;

   logic       clk;
   logic       rst;
   logic       cfg_start;
   logic       cfg_abort;
   logic       cfg_reuse_w;
   logic       w_valid;
   logic       w_ready;
   logic       px_valid;
   logic       px_ready;
   logic       pe_weight_control;
   logic       pe_start;
   logic       pe_top_start;
   logic       pe_side_control;
   logic       pe_top_control;
   logic       out_valid;
   logic       busy;
   logic       done;
   logic [2:0] state_dbg;
   logic [9:0] all_out;

   assign all_out = {w_ready, px_ready, pe_weight_control, pe_start, pe_top_start,
                     pe_side_control, pe_top_control, out_valid, busy, done};

   xnor_conv_sequencer #(.K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_start         (cfg_start),
      .cfg_abort         (cfg_abort),
`ifdef XNOR_SEQ_WEIGHT_REUSE_EN
      .cfg_reuse_w       (cfg_reuse_w),
`endif
      .w_valid           (w_valid),
      .w_ready           (w_ready),
      .px_valid          (px_valid),
      .px_ready          (px_ready),
      .pe_weight_control (pe_weight_control),
      .pe_start          (pe_start),
      .pe_top_start      (pe_top_start),
      .pe_side_control   (pe_side_control),
      .pe_top_control    (pe_top_control),
      .out_valid         (out_valid),
      .busy              (busy),
      .done              (done),
      .state_dbg         (state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   int cyc = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];   // pe_start ordinals at which out_valid must fire
   int ps_cnt     = 0;
   int beat       = 0;
   int ov_cnt     = 0;
   int done_cnt   = 0;
   int done_at    = 0;
   int wc_cnt     = 0;
   int drain_left = 0;
   int start_cyc  = 0;
   logic done_prev = 1'b0;
   int mr, mc;
   logic exp_ov;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Monitor: samples mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (rst) begin
         if (done_prev) check("busy_after_done", busy, 0);
         done_prev = done;
         if (done) begin
            done_cnt++;
            done_at = cyc;
         end
         if (pe_weight_control) wc_cnt++;
         if (w_ready) check("wctl_follows_valid", pe_weight_control, w_valid);
         if (px_ready) check("pe_start_follows_px", pe_start, px_valid);
         if (pe_start) begin
            ps_cnt++;
            exp_ov = (exp_q.size() > 0) && (exp_q[0] == ps_cnt);
            if (exp_ov) void'(exp_q.pop_front());
            check("out_valid", out_valid, exp_ov);
            if (out_valid) ov_cnt++;
         end else begin
            check("ov_without_start", out_valid, 0);
         end
         if (px_ready && px_valid) begin
            mr = beat / IMG_W;
            mc = beat % IMG_W;
            check("side_sel", pe_side_control, mc < K);
            check("top_sel", pe_top_control, (mc >= K) && (mr > 0));
            check("top_start", pe_top_start, 1);
            if (mr >= K - 1 && mc >= K - 1) exp_q.push_back(32'(ps_cnt + K));
            beat++;
            if (beat == IMG_W * IMG_H) drain_left = K;
         end else if (drain_left > 0) begin
            check("drain_start", pe_start, 1);
            check("drain_top_start", pe_top_start, 0);
            check("drain_px_ready", px_ready, 0);
            check("drain_side", pe_side_control, (IMG_W - 1) < K);
            check("drain_top", pe_top_control, ((IMG_W - 1) >= K) && (IMG_H > 1));
            drain_left--;
         end
      end else begin
         done_prev = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_layer(input logic reuse);
      beat = 0; ps_cnt = 0; ov_cnt = 0; done_cnt = 0; wc_cnt = 0; drain_left = 0;
      exp_q.delete();
      cfg_start   = 1'b1;
      cfg_reuse_w = reuse;
      start_cyc   = cyc;
      @(posedge clk); #1;
      cfg_start   = 1'b0;
      cfg_reuse_w = 1'b0;
      check("w_ready_after_start", w_ready, !reuse);
      check("px_ready_after_start", px_ready, reuse);
   endtask

   task automatic load_w(input int n, input int low_pct);
      int acc = 0;
      int guard = 0;
      while (acc < n && guard < 1000) begin
         w_valid = ($urandom_range(0, 99) >= low_pct);
         @(negedge clk);
         if (w_valid && w_ready) acc++;
         @(posedge clk); #1;
         guard++;
         check("px_ready_vs_wcount", px_ready, acc == K * K);
      end
      w_valid = 1'b0;
      check("w_accepted", acc, n);
   endtask

   task automatic stream_px(input int n, input int low_pct, input int abort_at);
      int acc = 0;
      int guard = 0;
      while (acc < n && guard < 2000) begin
         if (acc == abort_at) begin
            px_valid  = 1'b0;
            cfg_abort = 1'b1;
            @(posedge clk); #1;
            cfg_abort = 1'b0;
            check("abort_idle", {busy, px_ready}, 0);
            return;
         end
         px_valid = ($urandom_range(0, 99) >= low_pct);
         @(negedge clk);
         if (px_valid && px_ready) acc++;
         @(posedge clk); #1;
         guard++;
      end
      px_valid = 1'b0;
      check("px_accepted", acc, n);
   endtask

   task automatic finish_layer(input int exp_lat);
      int guard = 0;
      while (busy && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      check("layer_ended", busy, 0);
      check("ov_pulses", ov_cnt, N_WIN);
      check("done_pulses", done_cnt, 1);
      check("pending_windows", exp_q.size(), 0);
      if (exp_lat > 0) check("latency", done_at - start_cyc + 1, exp_lat);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_reuse_w = 1'b0;
      w_valid = 1'b0; px_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", all_out, 0);
      check("reset_state", state_dbg, 0);
      rst = 1'b1;

      // reset in the middle of weight loading
      start_layer(1'b0);
      load_w(4, 0);
      rst = 1'b0;
      #1;
      check("async_reset_outputs", all_out, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // nominal layer, no stalls
      start_layer(1'b0);
      load_w(K * K, 0);
      stream_px(IMG_W * IMG_H, 0, -1);
      finish_layer(LAT);

      // random pixel gaps (~30% low) and weight gaps
      start_layer(1'b0);
      load_w(K * K, 30);
      stream_px(IMG_W * IMG_H, 30, -1);
      finish_layer(-1);

      // abort after 20 pixel beats
      start_layer(1'b0);
      load_w(K * K, 0);
      stream_px(IMG_W * IMG_H, 20, 20);
      ov_cnt = 0;
      done_cnt = 0;
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_ov", ov_cnt, 0);
      check("abort_no_done", done_cnt, 0);
      check("abort_stays_idle", all_out, 0);

      // clean layer after the abort
      start_layer(1'b0);
      load_w(K * K, 20);
      stream_px(IMG_W * IMG_H, 10, -1);
      finish_layer(-1);
      check("weight_pulses", wc_cnt, K * K);

`ifdef XNOR_SEQ_WEIGHT_REUSE_EN
      start_layer(1'b1);
      stream_px(IMG_W * IMG_H, 30, -1);
      finish_layer(-1);
      check("reuse_no_weight_pulses", wc_cnt, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/xnor_conv_sequencer.md
# xnor_conv_sequencer

Control sequencer for a K×K systolic array of XNOR-popcount convolution PEs. It loads K·K binarized weights through the PE weight chain, then streams an IMG_H×IMG_W binary feature map through the array. It drives the shared per-array control strobes (weight load, compute start, top-register load, input-path select), flushes the popcount pipeline, and flags which popcount outputs are valid. It sits between the layer-level scheduler (cfg_* handshake) and the PE array (pe_* strobes).

## Interface
- K, 3, kernel size; array is K×K PEs; K ≥ 2
- IMG_W, 8, feature-map width in pixels; IMG_W ≥ K
- IMG_H, 8, feature-map height in pixels; IMG_H ≥ K
- CNT_W, 8, width of internal counters; must hold max(K·K, IMG_W, IMG_H)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_start  in  1  single-cycle request to run one layer; honoured only in IDLE
- cfg_abort  in  1  return to IDLE on next edge from any state
- w_valid / w_ready  in / out  1  weight-bit handshake; bit carried on the array weight_in
- px_valid / px_ready  in / out  1  pixel-beat handshake; pixel data goes straight to the array
- pe_weight_control  out  1  shift weight chain one stage
- pe_start  out  1  PE compute/advance strobe
- pe_top_start  out  1  PE top-register load strobe
- pe_side_control  out  1  PE input select: side path
- pe_top_control  out  1  PE input select: top register (used when side_control = 0)
- out_valid  out  1  popcount at array output is a valid window result this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a layer completes

## Operation
- States: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE: all outputs 0. cfg_start=1 moves to LOAD_W and clears all counters.
- LOAD_W: w_ready=1. pe_weight_control = w_valid (combinational). Each accepted bit increments w_cnt. The K·K-th acceptance moves to COMPUTE.
- COMPUTE: px_ready=1. For an accepted beat, pe_start = pe_top_start = 1. When px_valid=0, both strobes are 0 and all counters and the valid pipeline hold.
- COMPUTE counters: col runs 0..IMG_W-1 and wraps to 0 while row increments 0..IMG_H-1.
- Path selects are combinational from the current (col,row):
  - pe_side_control = (col < K).
  - pe_top_control = (col ≥ K) && (row > 0).
  - Both selects are 0 outside COMPUTE/DRAIN.
- Leaving COMPUTE: acceptance at (row=IMG_H-1, col=IMG_W-1) moves to DRAIN.
- Window tagging: a beat is tagged valid when col ≥ K-1 and row ≥ K-1. The tag enters a K-deep shift register that advances only when pe_start=1. out_valid = pipeline tail && pe_start.
- DRAIN: pe_start=1 for exactly K cycles, with pe_top_start=0 and px_ready=0. The selects use col=IMG_W-1 and row=IMG_H-1. After the K cycles, move to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Valid results per layer: exactly (IMG_W-K+1)·(IMG_H-K+1) out_valid pulses.
- cfg_abort has priority over every transition. On abort: next state IDLE, counters and valid pipeline cleared, done not pulsed.
- cfg_start outside IDLE is ignored.

## Timing
- Reset (async assert): state IDLE, counters and valid pipeline 0. All outputs 0 immediately, including w_ready and px_ready.
- Reset deassertion is sampled synchronously; the first cfg_start is accepted on the edge after rst goes high.
- Handshake outputs w_ready and px_ready are registered state decodes. A transfer occurs on an edge where valid && ready.
- cfg_start → w_ready high: 1 cycle.
- Last weight accepted → px_ready high: the next cycle.
- Accepted beat n tagged valid → out_valid: asserted on the K-th subsequent pe_start cycle.
- Minimum layer latency with no stalls: 1 + K·K + IMG_W·IMG_H + K + 1 cycles from cfg_start to done.
- Reset mid-operation discards all progress. The PE array must be reloaded.

## Configuration
- XNOR_SEQ_WEIGHT_REUSE_EN defined:
  - Adds input cfg_reuse_w (1 bit), sampled with cfg_start.
  - cfg_reuse_w=1 skips LOAD_W and goes IDLE→COMPUTE; w_ready stays 0.
  - Requires weights from a previous completed layer; otherwise behaviour is undefined.
- XNOR_SEQ_WEIGHT_REUSE_EN undefined: the port is absent and every run performs LOAD_W.

## Test plan
- Reset/idle: rst=0 mid-LOAD_W (after 4 bits) → all outputs 0 at once; after release plus cfg_start, w_ready=1 and w_cnt restarts at 0.
- Nominal K=3, 8×8, no stalls: 9 weight bits, 64 px beats → exactly 36 out_valid pulses, done at cycle 1+9+64+3+1=78 after cfg_start, busy=0 on the next cycle.
- Stalls: random px_valid gaps (30% low) → still 36 out_valid pulses; pe_start=0 on every gap cycle; out_valid never high when pe_start=0.
- Select decode: during row 0 → pe_top_control=0 throughout. During row 3 col 5 → side=0, top=1. During col 1 → side=1.
- Abort: cfg_abort at px beat 20 → IDLE next cycle, no done, no further out_valid; a following cfg_start runs a full clean layer.
- With XNOR_SEQ_WEIGHT_REUSE_EN: second run with cfg_reuse_w=1 → zero pe_weight_control pulses, px_ready=1 one cycle after cfg_start, 36 out_valid pulses.
